ctrl_bus_owner_arbiter: RTL and testbench

Arbitrates ownership of the single SCL/SDA bus pair between the two active-controller waveform engines: requester 0 is the I2C FSM and requester 1 is the I3C FSM. The block grants ownership round-robin and enforces a programmable bus-free interval before every grant. It muxes the owner's SCL/SDA drive and open-drain/push-pull select onto the PHY. It sits between the controller FSMs and the PHY and replaces the fixed per-engine wiring and the hard-tied driver select.

---
 rtl/ctrl_bus_owner_arbiter.sv | 93 +++++++++
 tb/tb_ctrl_bus_owner_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_bus_owner_arbiter.sv
// Round-robin SCL/SDA bus ownership arbiter between the I2C (0) and I3C (1) controller engines.
// A grant is issued only after both bus lines have been high for t_bus_free_i cycles.
module ctrl_bus_owner_arbiter #(
  parameter int unsigned TimerWidth = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [TimerWidth-1:0] t_bus_free_i,
  input  logic [1:0]            req_i,
  output logic [1:0]            gnt_o,
  input  logic [1:0]            req_scl_i,
  input  logic [1:0]            req_sda_i,
  input  logic [1:0]            req_pp_i,
  input  logic                  bus_scl_i,
  input  logic                  bus_sda_i,
  output logic                  scl_o,
  output logic                  sda_o,
  output logic                  sel_od_pp_o,
  output logic                  busy_o,
  output logic                  owner_o
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [TimerWidth-1:0] CntOne = TimerWidth'(1);
  localparam logic [TimerWidth-1:0] CntMax = '1;

  state_e                  state_q, state_d;
  logic [TimerWidth-1:0]   cnt_q, cnt_d;
  logic                    owner_q, owner_d;
  logic                    bus_high;
  logic                    bus_free;
  logic                    release_grant;

  assign bus_high = bus_scl_i & bus_sda_i;
  assign bus_free = bus_high & (cnt_q >= t_bus_free_i);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    release_grant = 1'b0;
    gnt_o         = 2'b00;
    scl_o         = 1'b1;
    sda_o         = 1'b1;
    sel_od_pp_o   = 1'b0;
    busy_o        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i && (req_i != 2'b00) && bus_free) begin
          state_d = StGrant;
          // On a tie the side that did not own the bus last wins.
          owner_d = (req_i == 2'b11) ? ~owner_q : req_i[1];
        end
      end
      StGrant: begin
        gnt_o[owner_q] = 1'b1;
        scl_o          = req_scl_i[owner_q];
        sda_o          = req_sda_i[owner_q];
        sel_od_pp_o    = req_pp_i[owner_q];
        busy_o         = 1'b1;
        if (!enable_i || !req_i[owner_q]) begin
          state_d       = StIdle;
          release_grant = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Free counter restarts on release so the next owner always sees a full bus-free interval.
  always_comb begin
    cnt_d = '0;
    if (enable_i && !release_grant && bus_high) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: tb/tb_ctrl_bus_owner_arbiter.sv
// Randomized bench for ctrl_bus_owner_arbiter against a cycle-level behavioural model,
// plus directed latency, round-robin and asynchronous-reset checks.
module tb_ctrl_bus_owner_arbiter;

  localparam int unsigned Tw = 4;
  localparam int CntMax = (1 << Tw) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable;
  logic [Tw-1:0] t_free;
  logic [1:0]    req, gnt, rq_scl, rq_sda, rq_pp;
  logic          bus_scl, bus_sda;
  logic          scl, sda, sel, busy, owner;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_free_cycles;

  always #5 clk = ~clk;

  ctrl_bus_owner_arbiter #(.TimerWidth(Tw)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .t_bus_free_i (t_free),
    .req_i        (req),
    .gnt_o        (gnt),
    .req_scl_i    (rq_scl),
    .req_sda_i    (rq_sda),
    .req_pp_i     (rq_pp),
    .bus_scl_i    (bus_scl),
    .bus_sda_i    (bus_sda),
    .scl_o        (scl),
    .sda_o        (sda),
    .sel_od_pp_o  (sel),
    .busy_o       (busy),
    .owner_o      (owner)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy        = 1'b0;
    m_owner       = 1;
    m_free_cycles = 0;
  endtask

  task automatic check_outputs();
    logic [1:0] e_gnt;
    e_gnt = 2'b00;
    if (m_busy) e_gnt[m_owner] = 1'b1;
    check_eq("gnt",   gnt,   e_gnt);
    check_eq("scl",   scl,   m_busy ? rq_scl[m_owner] : 1'b1);
    check_eq("sda",   sda,   m_busy ? rq_sda[m_owner] : 1'b1);
    check_eq("sel",   sel,   m_busy ? rq_pp[m_owner]  : 1'b0);
    check_eq("busy",  busy,  m_busy);
    check_eq("owner", owner, m_owner);
  endtask

  // One clock: inputs are already applied; check outputs, then advance model on the edge.
  task automatic tick();
    bit high, freed, released;
    #1;
    check_outputs();
    @(posedge clk);
    high     = bus_scl && bus_sda;
    freed    = high && (m_free_cycles >= int'(t_free));
    released = 1'b0;
    if (m_busy) begin
      if (!enable || !req[m_owner]) begin
        m_busy   = 1'b0;
        released = 1'b1;
      end
    end else if (enable && req != 2'b00 && freed) begin
      m_busy  = 1'b1;
      m_owner = (req == 2'b11) ? 1 - m_owner : (req[1] ? 1 : 0);
    end
    if (!enable || released || !high) m_free_cycles = 0;
    else if (m_free_cycles < CntMax) m_free_cycles++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Step until a grant is visible; returns the number of edges taken.
  task automatic wait_grant(input int budget, output int edges);
    edges = 0;
    while (gnt == 2'b00 && edges < budget) begin
      tick();
      edges++;
    end
    if (gnt == 2'b00) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_grant: no grant after %0d cycles", budget);
    end
  endtask

  initial begin
    int edges;
    enable = 1'b1; t_free = '0; req = 2'b00;
    rq_scl = 2'b00; rq_sda = 2'b00; rq_pp = 2'b00;
    bus_scl = 1'b1; bus_sda = 1'b1;
    model_reset();

    // Single I3C request, T=5: grant on the 6th edge
    apply_reset();
    t_free = 4'd5; req = 2'b10; rq_scl = 2'b10; rq_sda = 2'b00; rq_pp = 2'b10;
    wait_grant(40, edges);
    check_eq("i3c_latency", edges, 6);
    check_eq("i3c_gnt", gnt, 2'b10);
    check_eq("i3c_scl", scl, 1'b1);
    check_eq("i3c_pp", sel, 1'b1);

    // Tie after reset goes to requester 0, handover waits T+1 idle cycles
    apply_reset();
    t_free = 4'd3; req = 2'b11;
    wait_grant(40, edges);
    check_eq("tie_first", gnt, 2'b01);
    req = 2'b10;
    tick();
    wait_grant(40, edges);
    check_eq("handover_idle", edges, 4);
    check_eq("handover_gnt", gnt, 2'b10);
    req = 2'b00; tick(); req = 2'b11;
    wait_grant(40, edges);
    check_eq("tie_rr", gnt, 2'b01);

    // Bus-free restart: SDA low for one cycle at wait cycle 6 with T=8
    req = 2'b00; tick(); tick();
    t_free = 4'd8; req = 2'b01;
    repeat (6) tick();
    bus_sda = 1'b0; tick(); bus_sda = 1'b1;
    wait_grant(40, edges);
    check_eq("restart_delay", edges, 9);

    // No preemption by requester 1
    req = 2'b11;
    repeat (10) tick();
    check_eq("no_preempt", gnt, 2'b01);

    // Enable abort
    enable = 1'b0; tick();
    check_eq("abort_gnt", gnt, 2'b00);
    enable = 1'b1;

    // T=0 with SCL held low, then released
    req = 2'b00; tick();
    t_free = 4'd0; bus_scl = 1'b0; req = 2'b01;
    repeat (5) tick();
    check_eq("t0_scl_low", gnt, 2'b00);
    bus_scl = 1'b1;
    wait_grant(5, edges);
    check_eq("t0_latency", edges, 1);

    // Asynchronous reset mid-grant
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run with sticky requests
    t_free = 4'd2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req[0] = ~req[0];
      if ($urandom_range(7) == 0) req[1] = ~req[1];
      if ($urandom_range(63) == 0) t_free = Tw'($urandom_range(CntMax));
      enable  = ($urandom_range(40) != 0);
      bus_scl = ($urandom_range(15) != 0);
      bus_sda = ($urandom_range(15) != 0);
      rq_scl  = 2'($urandom);
      rq_sda  = 2'($urandom);
      rq_pp   = 2'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
